// File: rtl/dump_window_ctrl_if.sv
// Purpose: bundles the frame/download inputs and capture-window status outputs of dump_window_ctrl.
// Latency: none, wires only.
// Backpressure: none; the controller observes vs/downloading every cycle and cannot stall them.
// Ports (slave = controller side):
//   vs, downloading                in  : vertical sync and ROM-download flag, synchronous to clk
//   frame_cnt [FW]                 out : frames since arm point
//   dump_en, dump_on, dump_off     out : window level and one-cycle open/close pulses
//   win_idx [8], done              out : current/next window index, all windows completed
interface dump_window_ctrl_if #(
    parameter int unsigned FW = 32
);
    logic          vs;
    logic          downloading;
    logic [FW-1:0] frame_cnt;
    logic          dump_en;
    logic          dump_on;
    logic          dump_off;
    logic [7:0]    win_idx;
    logic          done;

    // Harness / stimulus side.
    modport master (
        output vs,
        output downloading,
        input  frame_cnt,
        input  dump_en,
        input  dump_on,
        input  dump_off,
        input  win_idx,
        input  done
    );

    // Window controller side.
    modport slave (
        input  vs,
        input  downloading,
        output frame_cnt,
        output dump_en,
        output dump_on,
        output dump_off,
        output win_idx,
        output done
    );
endinterface

// File: rtl/dump_window_ctrl.sv
// Purpose: counts vsync frames from an arm point and raises dump_en for programmable frame windows.
// Latency: one clock from the cycle a vs falling edge / download end is seen to all outputs.
// Backpressure: none; every vs falling edge and download transition is acted on the cycle it appears.
// Ports: clk, rst_n (async active-low); bus (dump_window_ctrl_if.slave) carries vs/downloading in
//        and frame_cnt, dump_en, dump_on, dump_off, win_idx, done out. All outputs are registered.
module dump_window_ctrl #(
    parameter int unsigned FW      = 32,
    parameter int unsigned START   = 0,
    parameter int unsigned LEN     = 1,
    parameter int unsigned PERIOD  = 0,
    parameter int unsigned WINDOWS = 1,
    parameter int unsigned MODE    = 0,
    parameter int unsigned HOLDOFF = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    dump_window_ctrl_if.slave   bus
);

    if (PERIOD != 0 && PERIOD <= LEN) begin : g_bad_period
        $error("dump_window_ctrl: PERIOD must be 0 or greater than LEN");
    end
    if (WINDOWS < 1 || WINDOWS > 255) begin : g_bad_windows
        $error("dump_window_ctrl: WINDOWS must be in 1..255");
    end
    if (MODE > 1) begin : g_bad_mode
        $error("dump_window_ctrl: MODE must be 0 or 1");
    end

    localparam int unsigned     HW       = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [HW-1:0]   HOLD_V   = HW'(HOLDOFF);
    localparam logic [FW-1:0]   START_V  = FW'(START);
    localparam logic [FW-1:0]   PERIOD_V = FW'(PERIOD);
    localparam logic [31:0]     LEN_V    = LEN;
    localparam logic [8:0]      WIN_V    = 9'(WINDOWS);
    localparam logic            MODE1    = (MODE == 1);
    localparam logic            SINGLE   = (PERIOD == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DUMP,
        S_GAP,
        S_DONE
    } state_t;

    // MODE 0 is armed straight out of reset; MODE 1 waits for a download to finish.
    localparam state_t RST_STATE = MODE1 ? S_IDLE : S_ARMED;

    state_t        state_q,      state_d;
    logic          vs_l_q,       vs_l_d;
    logic          dl_l_q,       dl_l_d;
    logic [HW-1:0] hold_cnt_q,   hold_cnt_d;
    logic [FW-1:0] frame_cnt_q,  frame_cnt_d;
    logic [FW-1:0] next_start_q, next_start_d;
    logic [31:0]   remain_q,     remain_d;
    logic [7:0]    win_idx_q,    win_idx_d;
    logic          dump_en_q,    dump_en_d;
    logic          dump_on_q,    dump_on_d;
    logic          dump_off_q,   dump_off_d;
    logic          done_q,       done_d;

    logic holdoff_ok;
    logic fe;
    logic de;
    logic dr;
    logic opens;
    logic last_win;

    always_comb begin
        holdoff_ok = (hold_cnt_q == HOLD_V);
        fe         = vs_l_q & ~bus.vs;
        de         = MODE1 & dl_l_q & ~bus.downloading & holdoff_ok;
        dr         = MODE1 & ~dl_l_q & bus.downloading;
        // Compare against the pre-increment count: the fe ending frame N opens window N.
        opens      = fe && (frame_cnt_q == next_start_q);
        last_win   = SINGLE || (({1'b0, win_idx_q} + 9'd1) == WIN_V);

        state_d      = state_q;
        vs_l_d       = bus.vs;
        dl_l_d       = bus.downloading;
        hold_cnt_d   = holdoff_ok ? hold_cnt_q : hold_cnt_q + HW'(1);
        frame_cnt_d  = frame_cnt_q;
        next_start_d = next_start_q;
        remain_d     = remain_q;
        win_idx_d    = win_idx_q;
        dump_en_d    = dump_en_q;
        dump_on_d    = 1'b0;
        dump_off_d   = 1'b0;
        done_d       = done_q;

        // A download end restarts frame numbering; it wins over a coincident frame edge.
        if (de) begin
            frame_cnt_d = '0;
        end else if (fe) begin
            frame_cnt_d = frame_cnt_q + FW'(1);
        end

        if (de) begin
            // Re-arm; a coincident fe is deliberately not used for comparison or remain.
            state_d      = S_ARMED;
            win_idx_d    = 8'd0;
            next_start_d = START_V;
            done_d       = 1'b0;
            if (dump_en_q) begin
                dump_en_d  = 1'b0;
                dump_off_d = 1'b1;
            end
        end else if (dr && (state_q inside {S_ARMED, S_DUMP, S_GAP})) begin
            // A new download aborts any capture in progress.
            state_d   = S_IDLE;
            win_idx_d = 8'd0;
            if (dump_en_q) begin
                dump_en_d  = 1'b0;
                dump_off_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_ARMED, S_GAP: begin
                    if (opens) begin
                        state_d      = S_DUMP;
                        dump_en_d    = 1'b1;
                        dump_on_d    = 1'b1;
                        remain_d     = LEN_V;
                        next_start_d = next_start_q + PERIOD_V;
                    end
                end
                S_DUMP: begin
                    // LEN == 0 leaves the window open indefinitely.
                    if (fe && (LEN_V != 32'd0)) begin
                        if (remain_q == 32'd1) begin
                            dump_en_d  = 1'b0;
                            dump_off_d = 1'b1;
                            win_idx_d  = win_idx_q + 8'd1;
                            if (last_win) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = S_GAP;
                            end
                        end else begin
                            remain_d = remain_q - 32'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RST_STATE;
            vs_l_q       <= 1'b0;
            dl_l_q       <= 1'b0;
            hold_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            next_start_q <= START_V;
            remain_q     <= '0;
            win_idx_q    <= 8'd0;
            dump_en_q    <= 1'b0;
            dump_on_q    <= 1'b0;
            dump_off_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_l_q       <= vs_l_d;
            dl_l_q       <= dl_l_d;
            hold_cnt_q   <= hold_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            next_start_q <= next_start_d;
            remain_q     <= remain_d;
            win_idx_q    <= win_idx_d;
            dump_en_q    <= dump_en_d;
            dump_on_q    <= dump_on_d;
            dump_off_q   <= dump_off_d;
            done_q       <= done_d;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
    assign bus.dump_en   = dump_en_q;
    assign bus.dump_on   = dump_on_q;
    assign bus.dump_off  = dump_off_q;
    assign bus.win_idx   = win_idx_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_dump_window_ctrl.sv
// Purpose: drives six differently-parameterised dump_window_ctrl instances from shared vs/downloading
//          stimulus and compares every output each cycle against a frame-arithmetic reference model.
// Latency/backpressure: n/a (testbench).
module tb_dump_window_ctrl;

    localparam int NI = 6;
    localparam int unsigned P_FW    [NI] = '{32, 32, 32,  4,  6,  8};
    localparam int unsigned P_START [NI] = '{ 3,  2,  1, 14, 60,  2};
    localparam int unsigned P_LEN   [NI] = '{ 2,  1,  2,  3,  2,  1};
    localparam int unsigned P_PER   [NI] = '{ 0,  4,  0,  0,  3,  2};
    localparam int unsigned P_WIN   [NI] = '{ 1,  3,  1,  1,  4,  5};
    localparam int unsigned P_MODE  [NI] = '{ 0,  0,  1,  0,  0,  1};
    localparam int unsigned P_HOLD  [NI] = '{16, 16, 16, 16,  0,  3};

    logic clk;
    logic rst_n;
    logic vs;
    logic dl;

    logic [31:0] o_fc   [NI];
    logic        o_en   [NI];
    logic        o_on   [NI];
    logic        o_off  [NI];
    logic [7:0]  o_idx  [NI];
    logic        o_done [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dump_window_ctrl_if #(.FW(P_FW[g])) ifc ();
        assign ifc.vs          = vs;
        assign ifc.downloading = dl;
        dump_window_ctrl #(
            .FW(P_FW[g]), .START(P_START[g]), .LEN(P_LEN[g]), .PERIOD(P_PER[g]),
            .WINDOWS(P_WIN[g]), .MODE(P_MODE[g]), .HOLDOFF(P_HOLD[g])
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc)
        );
        assign o_fc[g]   = 32'(ifc.frame_cnt);
        assign o_en[g]   = ifc.dump_en;
        assign o_on[g]   = ifc.dump_on;
        assign o_off[g]  = ifc.dump_off;
        assign o_idx[g]  = ifc.win_idx;
        assign o_done[g] = ifc.done;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: frames counted since arm, windows located by arithmetic.
    longint m_fc    [NI];
    longint m_nfe   [NI];
    bit     m_armed [NI];
    bit     m_en    [NI];
    bit     m_on    [NI];
    bit     m_off   [NI];
    bit     m_done  [NI];
    int     m_idx   [NI];
    bit     m_vsp;
    bit     m_dlp;
    int     cyc;

    function automatic int n_windows(int i);
        return (P_PER[i] == 0) ? 1 : int'(P_WIN[i]);
    endfunction

    // n = index (0-based) of the last frame edge seen since arm, -1 if none.
    function automatic bit in_win(int i, longint n);
        for (int k = 0; k < n_windows(i); k++) begin
            longint s = longint'(P_START[i]) + longint'(k) * longint'(P_PER[i]);
            if (n >= s && (P_LEN[i] == 0 || n < s + longint'(P_LEN[i]))) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int n_closed(int i, longint n);
        int c = 0;
        for (int k = 0; k < n_windows(i); k++) begin
            longint s = longint'(P_START[i]) + longint'(k) * longint'(P_PER[i]);
            if (P_LEN[i] != 0 && n >= s + longint'(P_LEN[i])) c++;
        end
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_fc[i]    = 0;
            m_nfe[i]   = 0;
            m_armed[i] = (P_MODE[i] == 0);
            m_en[i]    = 1'b0;
            m_on[i]    = 1'b0;
            m_off[i]   = 1'b0;
            m_done[i]  = 1'b0;
            m_idx[i]   = 0;
        end
        m_vsp = 1'b0;
        m_dlp = 1'b0;
        cyc   = 0;
    endtask

    task automatic model_step();
        bit fe;
        bit dr;
        fe = m_vsp & ~vs;
        dr = ~m_dlp & dl;
        for (int i = 0; i < NI; i++) begin
            bit de;
            bit old_en;
            de = (P_MODE[i] == 1) && m_dlp && !dl && (cyc >= int'(P_HOLD[i]));
            old_en = m_en[i];
            if (de) m_fc[i] = 0;
            else if (fe) m_fc[i] = (m_fc[i] + 1) % (64'd1 << P_FW[i]);
            if (de) begin
                m_armed[i] = 1'b1;
                m_nfe[i]   = 0;
            end else if (P_MODE[i] == 1 && dr && m_armed[i] && !m_done[i]) begin
                m_armed[i] = 1'b0;
            end else if (m_armed[i] && fe) begin
                m_nfe[i]++;
            end
            if (m_armed[i]) begin
                m_en[i]   = in_win(i, m_nfe[i] - 1);
                m_idx[i]  = n_closed(i, m_nfe[i] - 1);
                m_done[i] = (P_LEN[i] != 0) && (m_idx[i] == n_windows(i));
            end else begin
                m_en[i]   = 1'b0;
                m_idx[i]  = 0;
                m_done[i] = 1'b0;
            end
            m_on[i]  = !old_en && m_en[i];
            m_off[i] = old_en && !m_en[i];
        end
        m_vsp = vs;
        m_dlp = dl;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d.frame_cnt", i), o_fc[i], 32'(m_fc[i]));
            check($sformatf("u%0d.dump_en", i), 32'(o_en[i]), 32'(m_en[i]));
            check($sformatf("u%0d.dump_on", i), 32'(o_on[i]), 32'(m_on[i]));
            check($sformatf("u%0d.dump_off", i), 32'(o_off[i]), 32'(m_off[i]));
            check($sformatf("u%0d.win_idx", i), 32'(o_idx[i]), 32'(m_idx[i]));
            check($sformatf("u%0d.done", i), 32'(o_done[i]), 32'(m_done[i]));
        end
    endtask

    task automatic tick(input logic v, input logic d);
        vs = v;
        dl = d;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // One video frame: the falling edge of vs lands on the 4th tick.
    task automatic frame();
        for (int k = 0; k < 3; k++) tick(1'b1, dl);
        for (int k = 0; k < 3; k++) tick(1'b0, dl);
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    initial begin
        rst_n = 1'b0;
        vs    = 1'b0;
        dl    = 1'b1;
        model_reset();
        #23;
        check_all();
        rst_n = 1'b1;

        // Early download end inside the holdoff is ignored by the HOLDOFF=16 instance.
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("C ignores early de", o_fc[2], 32'd0);
        while (cyc < 40) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check("C armed frame_cnt", o_fc[2], 32'd0);
        check("C armed dump_en", 32'(o_en[2]), 32'd0);

        // START=1: window opens on the 2nd frame edge after arming.
        frame();
        check("C closed after 1 fe", 32'(o_en[2]), 32'd0);
        frame();
        check("C open after 2 fe", 32'(o_en[2]), 32'd1);

        // Abort mid-window.
        tick(1'b0, 1'b1);
        check("C abort dump_off", 32'(o_off[2]), 32'd1);
        check("C abort dump_en", 32'(o_en[2]), 32'd0);
        check("C abort win_idx", 32'(o_idx[2]), 32'd0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check("C rearm frame_cnt", o_fc[2], 32'd0);

        frames(2);
        check("C reopen", 32'(o_en[2]), 32'd1);
        check("A open after fe4", 32'(o_en[0]), 32'd1);
        check("A frame_cnt 4", o_fc[0], 32'd4);
        frames(4);
        check("A done", 32'(o_done[0]), 32'd1);
        check("A win_idx", 32'(o_idx[0]), 32'd1);
        check("A closed", 32'(o_en[0]), 32'd0);
        frames(4);
        check("B done", 32'(o_done[1]), 32'd1);
        check("B win_idx", 32'(o_idx[1]), 32'd3);
        frames(4);
        check("B no 4th window", 32'(o_en[1]), 32'd0);
        check("B win_idx stays", 32'(o_idx[1]), 32'd3);
        frame();
        check("D wrapped frame_cnt", o_fc[3], 32'd1);
        check("D open across wrap", 32'(o_en[3]), 32'd1);
        frame();
        check("D frame_cnt 2", o_fc[3], 32'd2);
        check("D done", 32'(o_done[3]), 32'd1);
        check("D closed", 32'(o_en[3]), 32'd0);

        // Reset, reopen A's window, then reset again inside it.
        #1 rst_n = 1'b0;
        model_reset();
        #20 rst_n = 1'b1;
        dl = 1'b0;
        frames(4);
        check("A open before reset", 32'(o_en[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("A async dump_en", 32'(o_en[0]), 32'd0);
        check("A no dump_off", 32'(o_off[0]), 32'd0);
        model_reset();
        #20 rst_n = 1'b1;
        tick(1'b0, 1'b0);
        check("A rearm frame_cnt", o_fc[0], 32'd0);

        // Randomised vs/downloading activity against the model.
        for (int k = 0; k < 3000; k++) begin
            logic v;
            logic d;
            v = vs ^ ($urandom_range(0, 2) == 0);
            d = dl ^ ($urandom_range(0, 39) == 0);
            tick(v, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
